ddos_hash_requester: RTL
========================

Name: ddos_hash_requester

Overview:
Front end of the DDoS source-rate filter. Passively taps the 64-bit NetFPGA packet stream and extracts the IPv4 source address of every packet. It queues each lookup, computes the hash-table address, and drives the hash_vld/src_ip/addr_hash request side of the hash table while respecting its busy and flush windows. It samples the table's drop result and emits one per-packet decision toward the output-queue drop logic.

Parameters:
DATA_WIDTH, 64, packet bus width; fixed, only 64 supported.
CTRL_WIDTH, 8, ctrl bus width.
MAX_DEPTH_BITS_HASH_TABLE, 14, hash address width; legal range 8..16.
REQ_FIFO_DEPTH_BITS, 2, log2 of pending-request queue depth (default 4 entries).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
in_data  in  64  tapped packet data.
in_ctrl  in  8  tapped ctrl; nonzero outside packet body and on the EOP word.
in_wr  in  1  word valid; no backpressure (passive tap).
src_ip  out  32  request IP, registered from the queue head.
addr_hash  out  MAX_DEPTH_BITS_HASH_TABLE  request address, from the queue head.
hash_vld  out  1  request strobe; combinational gate.
flush_1s  in  1  table flush request.
table_state  in  2  table FSM state; 0 means IDLE.
drop_pkt  in  1  table drop result.
src_ip_drop  in  32  table drop IP.
dec_vld  out  1  one-cycle decision strobe.
dec_drop  out  1  drop decision; valid with dec_vld.
dec_src_ip  out  32  IP the decision refers to.
req_overflow  out  1  one-cycle pulse when a request is discarded because the queue is full.
busy  out  1  queue non-empty or request in flight.

Behaviour:
- Reset: all outputs 0; queue emptied; parser in P_HDR; issuer in R_IDLE. A reset mid-request abandons the request and emits no decision.
- Parser, on in_wr only:
  - P_HDR: words with ctrl!=0 are module headers. The first word with ctrl==0 is word0; go to P_PKT with word index 1 for the next word.
  - P_PKT: a word with ctrl!=0 is EOP; return to P_HDR after it.
  - Word1: latch ipv4_ok = (in_data[31:16]==16'h0800) && (in_data[15:12]==4).
  - Word3: if ipv4_ok, ip = in_data[47:16]; enqueue {ip, hash(ip)}. This applies even when word3 is the EOP word.
  - Packets shorter than 4 words, or non-IPv4 packets, enqueue nothing.
  - Word index saturates after 3.
- Hash: XOR-fold ip in MAX_DEPTH_BITS_HASH_TABLE-bit chunks from bit 0 upward, with the top chunk zero-padded. For 14: ip[13:0]^ip[27:14]^{10'b0,ip[31:28]}.
- Queue: synchronous FIFO with a combinational head.
  - Enqueue when full: the entry is discarded, req_overflow=1 for that cycle, and the queue is unchanged.
  - Simultaneous enqueue and pop are both honoured.
- Issuer FSM (R_IDLE, R_WAIT, R_SAMPLE):
  - hash_vld = (R_IDLE && !empty && table_state==0 && !flush_1s). If flush_1s is high the request is held, never dropped.
  - src_ip and addr_hash equal the head from the hash_vld cycle through R_SAMPLE inclusive, because the table reads at T+1 and writes at T+2.
  - R_IDLE -> R_WAIT on hash_vld (cycle T).
  - R_WAIT -> R_SAMPLE unconditionally (T+1).
  - R_SAMPLE (T+2):
    - register dec_vld=1, dec_drop=drop_pkt && (src_ip_drop==head ip), dec_src_ip=head ip, visible at T+3;
    - pop the head;
    - go to R_IDLE.
  - The next hash_vld is possible at T+3, so throughput is one lookup per 3 cycles.
- busy = !empty || issuer != R_IDLE.

Optional Feature:
- Macro DDOS_REQ_STATS_EN.
- When defined, adds outputs stat_req (32), stat_drop (32) and stat_ovf (32). These are saturating counters of issued requests, dec_drop=1 decisions and req_overflow pulses. All three clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- IPv4 packet, src 0x0A000001, table in IDLE, drop_pkt=0:
  - hash_vld high 1 cycle after word3, with addr_hash=0x2801 and src_ip=0x0A000001;
  - dec_vld 3 cycles later with dec_drop=0 and dec_src_ip=0x0A000001.
- Same packet with drop_pkt=1 and src_ip_drop=0x0A000001 at T+2 -> dec_drop=1. With src_ip_drop=0x0A000002 -> dec_drop=0.
- Non-IPv4 or short packets:
  - ethertype 0x86DD -> no hash_vld and no dec_vld;
  - 3-word IPv4 packet -> no request.
- flush_1s=1 or table_state=2 while a request is pending -> hash_vld held 0. Issue occurs on the first cycle with table_state==0 && !flush_1s, and addr_hash is unchanged.
- 6 back-to-back minimum IPv4 packets with the table held busy (REQ_FIFO_DEPTH_BITS=2):
  - 4 entries queued;
  - req_overflow pulses twice;
  - after release, 4 decisions are emitted in arrival order, spaced 3 cycles apart.
- Reset asserted in R_WAIT -> next cycle hash_vld=0, dec_vld=0, busy=0, and no decision is emitted for the abandoned request.

Source files
------------

// File: rtl/ddos_hash_requester_if.sv
// Hash-table request/response bundle for the DDoS requester.
// master: drives hash_vld/src_ip/addr_hash; slave: drives flush_1s/table_state/drop_pkt/src_ip_drop.
interface ddos_hash_requester_if #(
    parameter int ADDR_W = 14
);
    logic              hash_vld;
    logic [31:0]       src_ip;
    logic [ADDR_W-1:0] addr_hash;
    logic              flush_1s;
    logic [1:0]        table_state;
    logic              drop_pkt;
    logic [31:0]       src_ip_drop;

    modport master (
        output hash_vld, src_ip, addr_hash,
        input  flush_1s, table_state, drop_pkt, src_ip_drop
    );

    modport slave (
        input  hash_vld, src_ip, addr_hash,
        output flush_1s, table_state, drop_pkt, src_ip_drop
    );
endinterface

// File: rtl/ddos_hash_requester.sv
// DDoS filter front end: taps the packet stream, queues IPv4 source lookups,
// issues them to the hash table and emits one drop decision per request.
// Ports: clk/reset (sync, active-high); in_data/in_ctrl/in_wr passive tap;
// tbl (master) hash-table request side; dec_vld/dec_drop/dec_src_ip decision;
// req_overflow pulse on a discarded request; busy while work is pending.
// Optional macro DDOS_REQ_STATS_EN adds stat_req/stat_drop/stat_ovf counters.
module ddos_hash_requester #(
    parameter int DATA_WIDTH                = 64,
    parameter int CTRL_WIDTH                = 8,
    parameter int MAX_DEPTH_BITS_HASH_TABLE = 14,
    parameter int REQ_FIFO_DEPTH_BITS       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    ddos_hash_requester_if.master tbl,
    output logic                  dec_vld,
    output logic                  dec_drop,
    output logic [31:0]           dec_src_ip,
    output logic                  req_overflow,
    output logic                  busy
`ifdef DDOS_REQ_STATS_EN
    ,
    output logic [31:0]           stat_req,
    output logic [31:0]           stat_drop,
    output logic [31:0]           stat_ovf
`endif
);

    localparam int AW    = MAX_DEPTH_BITS_HASH_TABLE;
    localparam int PW    = REQ_FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << PW;

    if (DATA_WIDTH != 64) begin : g_bad_dw
        $error("ddos_hash_requester: DATA_WIDTH must be 64");
    end
    if (AW < 8 || AW > 16) begin : g_bad_aw
        $error("ddos_hash_requester: hash width must be 8..16");
    end

    // XOR-fold the address in AW-bit chunks from bit 0; the top chunk
    // is zero-padded by the shift.
    function automatic logic [AW-1:0] fold_hash(input logic [31:0] ip);
        logic [AW-1:0] h;
        logic [31:0]   s;
        h = '0;
        s = ip;
        for (int i = 0; i < 32; i += AW) begin
            h = h ^ s[AW-1:0];
            s = s >> AW;
        end
        return h;
    endfunction

    // ---------------- parser ----------------
    typedef enum logic {P_HDR, P_PKT} pstate_t;

    pstate_t     p_state;
    logic [2:0]  word_idx;
    logic        ipv4_ok;
    logic [31:0] pkt_ip;
    logic [AW-1:0] pkt_hash;
    logic        enq;

    assign pkt_ip   = in_data[47:16];
    assign pkt_hash = fold_hash(pkt_ip);

    // Word3 enqueues even when it is also the EOP word.
    assign enq = in_wr && (p_state == P_PKT) &&
                 (word_idx == 3'd3) && ipv4_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_state  <= P_HDR;
            word_idx <= '0;
            ipv4_ok  <= 1'b0;
        end else if (in_wr) begin
            unique case (p_state)
                P_HDR: begin
                    if (in_ctrl == '0) begin
                        p_state  <= P_PKT;
                        word_idx <= 3'd1;
                        ipv4_ok  <= 1'b0;
                    end
                end
                P_PKT: begin
                    if (word_idx == 3'd1) begin
                        ipv4_ok <= (in_data[31:16] == 16'h0800) &&
                                   (in_data[15:12] == 4'd4);
                    end
                    // Index stops at 4 so later words never look like word3.
                    if (word_idx != 3'd4) begin
                        word_idx <= word_idx + 3'd1;
                    end
                    if (in_ctrl != '0) begin
                        p_state <= P_HDR;
                    end
                end
                default: p_state <= P_HDR;
            endcase
        end
    end

    // ---------------- request queue ----------------
    logic [31:0]   q_ip   [DEPTH];
    logic [AW-1:0] q_hash [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [31:0]   head_ip_q;
    logic [AW-1:0] head_hash_q;
    logic [31:0]   head_ip_next;
    logic [AW-1:0] head_hash_next;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign push  = enq && !full;

    // The head is kept in a register that already holds the entry
    // the queue will present after this cycle's push/pop.
    always_comb begin
        rd_next = rd_ptr;
        if (pop) begin
            rd_next = rd_ptr + PW'(1);
        end
        count_next = count + (PW+1)'(push) - (PW+1)'(pop);
        head_ip_next   = q_ip[rd_next];
        head_hash_next = q_hash[rd_next];
        if (push && (count == (PW+1)'(pop))) begin
            head_ip_next   = pkt_ip;
            head_hash_next = pkt_hash;
        end else if (count_next == '0) begin
            head_ip_next   = '0;
            head_hash_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_ip[wr_ptr]   <= pkt_ip;
            q_hash[wr_ptr] <= pkt_hash;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            head_ip_q    <= '0;
            head_hash_q  <= '0;
            req_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr       <= rd_next;
            count        <= count_next;
            head_ip_q    <= head_ip_next;
            head_hash_q  <= head_hash_next;
            req_overflow <= enq && full;
        end
    end

    // ---------------- issuer ----------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_SAMPLE
    } rstate_t;

    rstate_t r_state;
    logic    issue;

    // Held, never dropped, while the table is busy or flushing.
    assign issue = (r_state == R_IDLE) && !empty &&
                   (tbl.table_state == 2'd0) && !tbl.flush_1s;

    assign tbl.hash_vld  = issue;
    assign tbl.src_ip    = head_ip_q;
    assign tbl.addr_hash = head_hash_q;

    assign pop = (r_state == R_SAMPLE);

    // The table reads at T+1 and writes at T+2, so the head must stay
    // stable until the result is sampled in R_SAMPLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            dec_vld    <= 1'b0;
            dec_drop   <= 1'b0;
            dec_src_ip <= '0;
        end else begin
            dec_vld <= 1'b0;
            unique case (r_state)
                R_IDLE: begin
                    if (issue) begin
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: r_state <= R_SAMPLE;
                R_SAMPLE: begin
                    dec_vld    <= 1'b1;
                    dec_drop   <= tbl.drop_pkt &&
                                  (tbl.src_ip_drop == head_ip_q);
                    dec_src_ip <= head_ip_q;
                    r_state    <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign busy = !empty || (r_state != R_IDLE);

`ifdef DDOS_REQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_req  <= '0;
            stat_drop <= '0;
            stat_ovf  <= '0;
        end else begin
            if (issue && (stat_req != '1)) begin
                stat_req <= stat_req + 32'd1;
            end
            if (dec_vld && dec_drop && (stat_drop != '1)) begin
                stat_drop <= stat_drop + 32'd1;
            end
            if (req_overflow && (stat_ovf != '1)) begin
                stat_ovf <= stat_ovf + 32'd1;
            end
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{in_data[DATA_WIDTH-1:48], in_data[11:0]};

endmodule
